// File: rtl/eth_phy_init.sv
// RTL8211EG bring-up sequencer: waits out PHY settle after e_reset, checks the
// PHY identity, starts auto-negotiation, then polls register 17 for link status.
module eth_phy_init #(
   parameter logic [4:0]  PHY_ADDR = 5'd1,
   parameter int          MDC_DIV  = 10,
   parameter int          WAIT_CYC = 1500000,
   parameter int          POLL_CYC = 500000,
   parameter logic [15:0] PHY_ID1  = 16'h001C,
   parameter logic [15:0] BMCR_VAL = 16'h1340,
   parameter int          ID_RETRY = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       e_reset,
   input  logic       mdio_i,
   output logic       mdc,
   output logic       mdio_o,
   output logic       mdio_oe,
   output logic       phy_ready,
   output logic       link_up,
   output logic [1:0] speed,
   output logic       duplex,
   output logic       id_err,
   output logic       busy
);

   // state    | meaning
   // S_IDLE   | held while e_reset is high; leaves as soon as it is low
   // S_WAIT   | settle delay (WAIT_CYC), or POLL_CYC before an identity retry
   // S_RD_ID  | read frame of register 2 in flight
   // S_CHK_ID | compare identity, retry or give up
   // S_WR_BMCR| write frame of BMCR_VAL to register 0 in flight
   // S_RD_SR  | read frame of register 17 in flight
   // S_UPDATE | load link/speed/duplex from the captured data
   // S_POLL   | POLL_CYC delay between status reads
   // S_ERR    | identity failed; parked until rst or e_reset
   typedef enum logic [3:0] {
      S_IDLE, S_WAIT, S_RD_ID, S_CHK_ID, S_WR_BMCR, S_RD_SR, S_UPDATE, S_POLL, S_ERR
   } state_t;

   localparam int CMAX = (WAIT_CYC > POLL_CYC) ? WAIT_CYC : POLL_CYC;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int DW   = $clog2(MDC_DIV + 1);
   localparam int RW   = $clog2(ID_RETRY + 1);
   localparam logic [CW-1:0] WAIT_LAST  = CW'(WAIT_CYC - 1);
   localparam logic [CW-1:0] POLL_LAST  = CW'(POLL_CYC - 1);
   localparam logic [DW-1:0] DIV_LAST   = DW'(MDC_DIV - 1);
   localparam logic [RW-1:0] RETRY_LAST = RW'(ID_RETRY - 1);

   function automatic logic [63:0] mk_frame(input logic rd, input logic [4:0] regad,
                                            input logic [15:0] data);
      return {32'hFFFF_FFFF, 2'b01, rd ? 2'b10 : 2'b01, PHY_ADDR, regad,
              rd ? 2'b11 : 2'b10, rd ? 16'hFFFF : data};
   endfunction

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic            poll_wait_q;
   logic [RW-1:0]   retry_q;
   logic [DW-1:0]   div_q;
   logic [5:0]      bit_q;
   logic [63:0]     tx_q;
   logic [15:0]     rx_q;
   logic            rd_q;
   logic            done_q;
   logic            mdc_q;
   logic            mdo_q;
   logic            oe_q;
   logic            busy_q;
   logic            ready_q;
   logic            link_q;
   logic [1:0]      speed_q;
   logic            dup_q;
   logic            err_q;

   logic            wait_done;
   logic            poll_done;
   logic            id_ok;
   logic            start_wr;
   logic            start_sr;
   logic            start;
   logic [63:0]     tx_d;

   always_comb begin
      wait_done = (state_q == S_WAIT) && (cnt_q == (poll_wait_q ? POLL_LAST : WAIT_LAST));
      poll_done = (state_q == S_POLL) && (cnt_q == POLL_LAST);
      id_ok     = (state_q == S_CHK_ID) && (rx_q == PHY_ID1);
      start_wr  = id_ok;
      start_sr  = ((state_q == S_WR_BMCR) && done_q) || poll_done;
      start     = wait_done || start_wr || start_sr;
      tx_d      = start_wr ? mk_frame(1'b0, 5'd0, BMCR_VAL)
                           : mk_frame(1'b1, start_sr ? 5'd17 : 5'd2, 16'h0000);
   end

   // Frame engine: tx_q holds the bits still to be sent; the current bit sits in mdo_q.
   always_ff @(posedge clk) begin
      if (rst || e_reset) begin
         busy_q <= 1'b0;
         mdc_q  <= 1'b0;
         mdo_q  <= 1'b1;
         oe_q   <= 1'b0;
         div_q  <= '0;
         bit_q  <= '0;
         tx_q   <= '0;
         rx_q   <= '0;
         rd_q   <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start) begin
            tx_q   <= {tx_d[62:0], 1'b1};
            rd_q   <= !start_wr;
            busy_q <= 1'b1;
            div_q  <= DIV_LAST;
            mdc_q  <= 1'b0;
            bit_q  <= '0;
            mdo_q  <= tx_d[63];
            oe_q   <= 1'b1;
         end else if (busy_q) begin
            if (div_q == DIV_LAST) begin
               div_q <= '0;
               mdc_q <= ~mdc_q;
               if (!mdc_q) begin
                  rx_q <= {rx_q[14:0], mdio_i};
               end else if (bit_q == 6'd63) begin
                  busy_q <= 1'b0;
                  oe_q   <= 1'b0;
                  mdo_q  <= 1'b1;
                  done_q <= 1'b1;
               end else begin
                  bit_q <= bit_q + 6'd1;
                  tx_q  <= {tx_q[62:0], 1'b1};
                  // read frames release the bus from the first turnaround bit onward
                  if (rd_q && (bit_q >= 6'd45)) begin
                     oe_q  <= 1'b0;
                     mdo_q <= 1'b1;
                  end else begin
                     oe_q  <= 1'b1;
                     mdo_q <= tx_q[63];
                  end
               end
            end else begin
               div_q <= div_q + DW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || e_reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         poll_wait_q <= 1'b0;
         retry_q     <= '0;
         ready_q     <= 1'b0;
         link_q      <= 1'b0;
         speed_q     <= 2'b00;
         dup_q       <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_q     <= S_WAIT;
               cnt_q       <= '0;
               poll_wait_q <= 1'b0;
            end
            S_WAIT: begin
               if (wait_done) state_q <= S_RD_ID;
               else           cnt_q   <= cnt_q + CW'(1);
            end
            S_RD_ID: if (done_q) state_q <= S_CHK_ID;
            S_CHK_ID: begin
               if (id_ok) begin
                  state_q <= S_WR_BMCR;
               end else if (retry_q < RETRY_LAST) begin
                  retry_q     <= retry_q + RW'(1);
                  state_q     <= S_WAIT;
                  cnt_q       <= '0;
                  poll_wait_q <= 1'b1;
               end else begin
                  retry_q <= retry_q + RW'(1);
                  err_q   <= 1'b1;
                  state_q <= S_ERR;
               end
            end
            S_WR_BMCR: begin
               if (done_q) begin
                  ready_q <= 1'b1;
                  state_q <= S_RD_SR;
               end
            end
            S_RD_SR: if (done_q) state_q <= S_UPDATE;
            S_UPDATE: begin
               link_q  <= rx_q[10];
               speed_q <= rx_q[15:14];
               dup_q   <= rx_q[13];
               cnt_q   <= '0;
               state_q <= S_POLL;
            end
            S_POLL: begin
               if (poll_done) state_q <= S_RD_SR;
               else           cnt_q   <= cnt_q + CW'(1);
            end
            S_ERR: state_q <= S_ERR;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign mdc       = mdc_q;
   assign mdio_o    = mdo_q;
   assign mdio_oe   = oe_q;
   assign busy      = busy_q;
   assign phy_ready = ready_q;
   assign link_up   = link_q;
   assign speed     = speed_q;
   assign duplex    = dup_q;
   assign id_err    = err_q;

endmodule

// File: tb/tb_eth_phy_init.sv
// Bench for eth_phy_init: MDIO PHY model, frame decoder and status reference model.
module tb_eth_phy_init;

   localparam int MDC_DIV  = 2;
   localparam int WAIT_CYC = 40;
   localparam int POLL_CYC = 60;

   logic       clk = 1'b0;
   logic       rst;
   logic       e_reset;
   logic       mdio_i = 1'b1;
   logic       mdc, mdio_o, mdio_oe, phy_ready, link_up, duplex, id_err, busy;
   logic [1:0] speed;

   eth_phy_init #(
      .PHY_ADDR(5'd1), .MDC_DIV(MDC_DIV), .WAIT_CYC(WAIT_CYC), .POLL_CYC(POLL_CYC),
      .PHY_ID1(16'h001C), .BMCR_VAL(16'h1340), .ID_RETRY(3)
   ) dut (
      .clk(clk), .rst(rst), .e_reset(e_reset), .mdio_i(mdio_i),
      .mdc(mdc), .mdio_o(mdio_o), .mdio_oe(mdio_oe), .phy_ready(phy_ready),
      .link_up(link_up), .speed(speed), .duplex(duplex), .id_err(id_err), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   typedef struct {
      int          start;
      int          gap;
      int          first_rise;
      logic [1:0]  st;
      logic [1:0]  op;
      logic [4:0]  phyad;
      logic [4:0]  regad;
      logic [1:0]  ta;
      logic [15:0] data;
   } frame_t;

   frame_t      frames[$];
   frame_t      fr;
   logic [15:0] phy_reg2, phy_reg17;
   bit          mon_en = 1'b0;
   int          rise_cnt = 0;
   int          nbits = 0;
   logic [63:0] sh = '0, oe_sh = '0;
   logic        rd_act = 1'b0;
   logic [15:0] rd_val = '0;
   int          f_start = 0, f_first = 0, last_fall = 0;
   logic        mdc_p, busy_p, oe_p, o_p;
   logic [5:0]  st_p;

   // PHY model + frame decoder; all sampling on the falling clk edge.
   always @(negedge clk) begin
      if (mon_en) begin
         if ((mdio_oe !== oe_p) || (mdio_o !== o_p))
            chk("mdio_timing", ((mdc_p && !mdc) || (busy !== busy_p)), 1'b1);
         if ({phy_ready, id_err, link_up, speed, duplex} !== st_p)
            chk("status_mid_frame", busy_p && busy, 1'b0);
         if (busy && !busy_p) begin
            f_start = cyc;
            nbits   = 0;
         end
         if (!busy && busy_p) begin
            last_fall = cyc;
            nbits     = 0;
            rd_act    = 1'b0;
            mdio_i    = 1'b1;
         end
         if (mdc && !mdc_p) begin
            rise_cnt++;
            if (nbits == 0) f_first = cyc;
            sh    = {sh[62:0], mdio_o};
            oe_sh = {oe_sh[62:0], mdio_oe};
            nbits++;
            if (nbits == 46) begin
               rd_act = (sh[11:10] == 2'b10);
               rd_val = (sh[4:0] == 5'd2) ? phy_reg2 : (sh[4:0] == 5'd17) ? phy_reg17 : 16'hFFFF;
            end
            if (nbits == 64) begin
               fr.start      = f_start;
               fr.gap        = f_start - last_fall;
               fr.first_rise = f_first;
               fr.st         = sh[31:30];
               fr.op         = sh[29:28];
               fr.phyad      = sh[27:23];
               fr.regad      = sh[22:18];
               fr.ta         = sh[17:16];
               fr.data       = rd_act ? rd_val : sh[15:0];
               chk("oe_pattern", oe_sh,
                   (sh[29:28] == 2'b10) ? 64'hFFFF_FFFF_FFFC_0000 : 64'hFFFF_FFFF_FFFF_FFFF);
               frames.push_back(fr);
               nbits  = 0;
               rd_act = 1'b0;
               mdio_i = 1'b1;
            end else if (rd_act) begin
               mdio_i = (nbits == 46) ? 1'b1 : (nbits == 47) ? 1'b0 : rd_val[4'(63 - nbits)];
            end
         end
      end
      mdc_p  = mdc;
      busy_p = busy;
      oe_p   = mdio_oe;
      o_p    = mdio_o;
      st_p   = {phy_ready, id_err, link_up, speed, duplex};
   end

   // Reference model: register 17 field extraction.
   function automatic logic [3:0] model_status(input logic [15:0] v);
      int lnk, spd, dpx;
      lnk = (int'(v) / 1024) % 2;
      spd = (int'(v) / 16384) % 4;
      dpx = (int'(v) / 8192) % 2;
      return {1'(lnk), 2'(spd), 1'(dpx)};
   endfunction

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_frames(input int n, input string nm);
      int k = 0;
      while (frames.size() < n && k < 6000) begin
         @(negedge clk);
         k++;
      end
      chk(nm, frames.size() >= n, 1'b1);
   endtask

   task automatic release_ereset(output int t0);
      frames.delete();
      e_reset = 1'b0;
      @(negedge clk);
      t0 = cyc;
   endtask

   typedef struct {
      logic [15:0] reg2;
      logic [15:0] reg17;
      logic [5:0]  exp;   // {phy_ready, id_err, link_up, speed, duplex}
   } vec_t;

   vec_t vecs[7];
   int   t0, k, rc;
   logic [15:0] rv;

   initial begin
      vecs[0] = '{16'h001C, 16'hAC00, 6'b101101};
      vecs[1] = '{16'h001C, 16'h6400, 6'b101011};
      vecs[2] = '{16'h001C, 16'h0000, 6'b100000};
      vecs[3] = '{16'h001C, 16'h8000, 6'b100100};
      vecs[4] = '{16'h001C, 16'h0400, 6'b101000};
      vecs[5] = '{16'h1234, 16'hAC00, 6'b010000};
      vecs[6] = '{16'h001D, 16'h6400, 6'b010000};

      rst = 1'b1; e_reset = 1'b1;
      phy_reg2 = 16'h001C; phy_reg17 = 16'hAC00;
      wait_cyc(3);
      mon_en = 1'b1;
      chk("reset_outputs", {mdc, mdio_o, mdio_oe, phy_ready, link_up, speed, duplex, id_err, busy},
          10'b0100000000);
      rst = 1'b0;
      wait_cyc(100);
      release_ereset(t0);

      // nominal bring-up
      wait_frames(3, "bringup_frames");
      if (frames.size() >= 3) begin
         chk("first_mdc_latency", frames[0].first_rise - t0, WAIT_CYC + 1);
         chk("rd_id_header", {frames[0].st, frames[0].op, frames[0].phyad, frames[0].regad},
             {2'b01, 2'b10, 5'd1, 5'd2});
         chk("wr_bmcr_frame", {frames[1].st, frames[1].op, frames[1].phyad, frames[1].regad,
             frames[1].ta, frames[1].data}, {2'b01, 2'b01, 5'd1, 5'd0, 2'b10, 16'h1340});
         chk("rd_sr_header", {frames[2].st, frames[2].op, frames[2].phyad, frames[2].regad},
             {2'b01, 2'b10, 5'd1, 5'd17});
      end
      wait_cyc(8);
      chk("bringup_status", {phy_ready, id_err, link_up, speed, duplex}, 6'b101101);

      // link drop between polls
      phy_reg17 = 16'h0000;
      wait_frames(4, "linkdrop_frame");
      if (frames.size() >= 4)
         chk("poll_gap", (frames[3].gap >= POLL_CYC) && (frames[3].gap <= POLL_CYC + 4), 1'b1);
      wait_cyc(8);
      chk("linkdrop_status", {phy_ready, link_up, speed, duplex}, 5'b10000);

      // abort a status read at bit 40
      phy_reg17 = 16'hAC00;
      wait_frames(5, "relink_frame");
      wait_cyc(8);
      chk("relink_status", {link_up, speed, duplex}, 4'b1101);
      k = 0;
      while (!(busy && nbits == 40) && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk("reach_bit40", busy && nbits == 40, 1'b1);
      e_reset = 1'b1;
      @(negedge clk);
      chk("abort_outputs", {mdio_oe, mdc, busy, phy_ready, link_up, speed, duplex, id_err, mdio_o},
          10'b0000000001);
      wait_cyc(5);
      release_ereset(t0);
      wait_frames(1, "restart_frame");
      if (frames.size() >= 1) begin
         chk("restart_latency", frames[0].first_rise - t0, WAIT_CYC + 1);
         chk("restart_regad", frames[0].regad, 5'd2);
      end

      // table-driven identity / status vectors
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         e_reset   = 1'b1;
         phy_reg2  = vecs[i].reg2;
         phy_reg17 = vecs[i].reg17;
         wait_cyc(4);
         release_ereset(t0);
         wait_frames(3, "vec_frames");
         if (vecs[i].exp[5]) begin
            wait_cyc(8);
         end else begin
            wait_cyc(2 * MDC_DIV + 10);
            rc = rise_cnt;
            wait_cyc(400);
            chk("no_mdc_after_err", rise_cnt - rc, 0);
            chk("id_read_count", frames.size(), 3);
            if (frames.size() >= 3) begin
               chk("id_reads_reg2", {frames[0].regad, frames[1].regad, frames[2].regad,
                   frames[0].op, frames[1].op, frames[2].op}, {5'd2, 5'd2, 5'd2, 6'b101010});
               chk("id_retry_gap", (frames[1].gap >= POLL_CYC) && (frames[2].gap >= POLL_CYC), 1'b1);
            end
         end
         chk("vec_status", {phy_ready, id_err, link_up, speed, duplex}, vecs[i].exp);
      end

      // rst together with e_reset on the UPDATE cycle
      @(negedge clk);
      e_reset = 1'b1; phy_reg2 = 16'h001C; phy_reg17 = 16'hAC00;
      wait_cyc(4);
      release_ereset(t0);
      wait_frames(3, "upd_frames");
      k = 0;
      while (busy && k < 100) begin
         @(negedge clk);
         k++;
      end
      @(negedge clk);
      rst = 1'b1; e_reset = 1'b1;
      @(negedge clk);
      chk("reset_in_update", {mdc, mdio_o, mdio_oe, phy_ready, link_up, speed, duplex, id_err, busy},
          10'b0100000000);
      wait_cyc(2);
      rst = 1'b0;
      wait_cyc(3);

      // randomized status polling against the reference model
      release_ereset(t0);
      wait_frames(2, "rand_init");
      for (int i = 0; i < 8; i++) begin
         rv = 16'($urandom);
         phy_reg17 = rv;
         wait_frames(3 + i, "rand_poll");
         wait_cyc(8);
         chk("rand_status", {link_up, speed, duplex}, model_status(rv));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
